// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction fetch stage and IF/ID pipeline register
// Optional macro IF_PERF_CNT_EN adds saturating fetch/stall performance counters.
module if_fetch_stage #(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]          NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [31:0]         ifid_instr,
  output logic [PC_WIDTH-1:0] ifid_pc4,
  output logic                ifid_valid,
  output logic [5:0]          next_opCode
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t              state_q;
  logic                req_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] redir_q;
  logic [31:0]         buf_instr_q;
  logic [PC_WIDTH-1:0] buf_pc4_q;
  logic [31:0]         instr_q;
  logic [PC_WIDTH-1:0] pc4_q;
  logic                valid_q;

  logic                accept;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] redir_pc;
  logic                unused_tgt_bits;

  assign accept          = req_q & imem_ready;
  assign pc_plus4        = pc_q + PC_WIDTH'(4);
  assign redir_pc        = {branch_target[PC_WIDTH-1:2], 2'b00};
  assign unused_tgt_bits = ^branch_target[1:0];

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign ifid_instr  = instr_q;
  assign ifid_pc4    = pc4_q;
  assign ifid_valid  = valid_q;
  assign next_opCode = valid_q ? instr_q[31:26] : 6'h00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      req_q       <= 1'b0;
      pc_q        <= RESET_PC;
      redir_q     <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_pc4_q   <= '0;
      instr_q     <= NOP_INSTR;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          req_q <= 1'b1;
          if (branch_taken) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            // An unanswered request must complete at its old address first.
            if (req_q && !imem_ready) begin
              redir_q <= redir_pc;
              state_q <= S_DROP;
            end else begin
              pc_q <= redir_pc;
            end
          end else if (accept) begin
            pc_q <= pc_plus4;
            if (stall) begin
              buf_instr_q <= imem_rdata;
              buf_pc4_q   <= pc_plus4;
              req_q       <= 1'b0;
              state_q     <= S_HOLD;
            end else begin
              instr_q <= imem_rdata;
              pc4_q   <= pc_plus4;
              valid_q <= 1'b1;
            end
          end else if (!stall) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end
        end
        S_HOLD: begin
          if (branch_taken) begin
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
            buf_instr_q <= NOP_INSTR;
            pc_q        <= redir_pc;
            req_q       <= 1'b1;
            state_q     <= S_FETCH;
          end else if (!stall) begin
            instr_q <= buf_instr_q;
            pc4_q   <= buf_pc4_q;
            valid_q <= 1'b1;
            req_q   <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_DROP: begin
          if (branch_taken) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            redir_q <= redir_pc;
          end
          if (imem_ready) begin
            pc_q    <= branch_taken ? redir_pc : redir_q;
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_ev;
  assign fetch_ev = (state_q == S_FETCH) && accept && !branch_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fetch_ev && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] R   = 32'h8C08_0004;
  localparam logic [31:0] W2  = 32'h2000_0002;
  localparam logic [31:0] W3  = 32'h2400_0003;
  localparam logic [31:0] W4  = 32'hAC00_0004;
  localparam logic [31:0] W5  = 32'h0800_0040;
  localparam logic [31:0] W6  = 32'h3C01_1234;
  localparam logic [31:0] W7  = 32'h1000_0007;
  localparam logic [31:0] W8  = 32'h2800_0008;
  localparam logic [31:0] W9  = 32'h0C00_0009;
  localparam logic [31:0] W10 = 32'h2C00_000A;
  localparam logic [31:0] JNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  next_opCode;

  int n_vec = 0;
  int n_bad = 0;

  if_fetch_stage #(
    .PC_WIDTH(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid),
    .next_opCode(next_opCode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t tbl[24];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } held_t;

  // Reference model: an address cursor, a queue for a word fetched under stall,
  // and a pending redirect that waits out the outstanding request.
  logic [31:0] m_pc;
  bit          m_req;
  held_t       m_held[$];
  bit          m_drop;
  logic [31:0] m_redir;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  bit          m_valid;

  task automatic model_reset();
    m_pc = 32'h0; m_req = 0; m_held.delete(); m_drop = 0; m_redir = 32'h0;
    m_instr = NOP; m_pc4 = 32'h0; m_valid = 0;
  endtask

  task automatic model_step(input bit rdy, input logic [31:0] rd, input bit stl,
                            input bit br, input logic [31:0] tgt_raw);
    logic [31:0] tgt;
    held_t h;
    tgt = tgt_raw & 32'hFFFF_FFFC;
    if (br) begin
      m_instr = NOP; m_valid = 0; m_held.delete();
      if (m_drop) begin
        m_redir = tgt;
        if (rdy) begin m_pc = tgt; m_drop = 0; end
      end else if (m_req && !rdy) begin
        m_drop = 1; m_redir = tgt;
      end else begin
        m_pc = tgt;
      end
      m_req = 1;
    end else if (m_drop) begin
      if (rdy) begin m_pc = m_redir; m_drop = 0; end
    end else if (m_held.size() > 0) begin
      if (!stl) begin
        h = m_held.pop_front();
        m_instr = h.instr; m_pc4 = h.pc4; m_valid = 1; m_req = 1;
      end
    end else if (m_req && rdy) begin
      if (stl) begin
        h.instr = rd; h.pc4 = m_pc + 32'd4;
        m_held.push_back(h); m_req = 0;
      end else begin
        m_instr = rd; m_pc4 = m_pc + 32'd4; m_valid = 1;
      end
      m_pc = m_pc + 32'd4;
    end else begin
      if (!stl) begin m_instr = NOP; m_valid = 0; end
      m_req = 1;
    end
  endtask

  task automatic check(input string name, input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4,
                       input logic e_valid, input logic chk_pc4);
    logic [5:0] e_op;
    e_op = e_valid ? e_instr[31:26] : 6'h00;
    n_vec++;
    if (imem_req !== e_req || imem_addr !== e_addr || ifid_instr !== e_instr ||
        ifid_valid !== e_valid || next_opCode !== e_op ||
        (chk_pc4 && ifid_pc4 !== e_pc4)) begin
      n_bad++;
      $display("FAIL %s: got req=%b addr=%h instr=%h pc4=%h valid=%b op=%h, want req=%b addr=%h instr=%h pc4=%h valid=%b op=%h",
               name, imem_req, imem_addr, ifid_instr, ifid_pc4, ifid_valid, next_opCode,
               e_req, e_addr, e_instr, e_pc4, e_valid, e_op);
    end
  endtask

  task automatic drive(input logic rdy, input logic [31:0] rd, input logic stl,
                       input logic br, input logic [31:0] tgt);
    imem_ready = rdy; imem_rdata = rd; stall = stl; branch_taken = br; branch_target = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, R,   1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         NOP, 32'h0,   1'b0};
    tbl[1]  = '{1'b1, R,   1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         R,   32'h4,   1'b1};
    tbl[2]  = '{1'b1, W2,  1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         W2,  32'h8,   1'b1};
    tbl[3]  = '{1'b1, W3,  1'b1, 1'b0, 32'h0,         1'b0, 32'hC,         W2,  32'h8,   1'b1};
    tbl[4]  = '{1'b1, JNK, 1'b1, 1'b0, 32'h0,         1'b0, 32'hC,         W2,  32'h8,   1'b1};
    tbl[5]  = '{1'b0, JNK, 1'b1, 1'b0, 32'h0,         1'b0, 32'hC,         W2,  32'h8,   1'b1};
    tbl[6]  = '{1'b1, JNK, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         W3,  32'hC,   1'b1};
    tbl[7]  = '{1'b1, W4,  1'b0, 1'b0, 32'h0,         1'b1, 32'h10,        W4,  32'h10,  1'b1};
    tbl[8]  = '{1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h103, 1'b1, 32'h100,   NOP, 32'h0,   1'b0};
    tbl[9]  = '{1'b1, W5,  1'b0, 1'b0, 32'h0,         1'b1, 32'h104,       W5,  32'h104, 1'b1};
    tbl[10] = '{1'b1, JNK, 1'b0, 1'b1, 32'h8,         1'b1, 32'h8,         NOP, 32'h0,   1'b0};
    tbl[11] = '{1'b0, JNK, 1'b0, 1'b1, 32'h200,       1'b1, 32'h8,         NOP, 32'h0,   1'b0};
    tbl[12] = '{1'b0, JNK, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         NOP, 32'h0,   1'b0};
    tbl[13] = '{1'b0, JNK, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         NOP, 32'h0,   1'b0};
    tbl[14] = '{1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200,     NOP, 32'h0,   1'b0};
    tbl[15] = '{1'b1, W6,  1'b0, 1'b0, 32'h0,         1'b1, 32'h204,       W6,  32'h204, 1'b1};
    tbl[16] = '{1'b1, W7,  1'b0, 1'b0, 32'h0,         1'b1, 32'h208,       W7,  32'h208, 1'b1};
    tbl[17] = '{1'b0, JNK, 1'b1, 1'b0, 32'h0,         1'b1, 32'h208,       W7,  32'h208, 1'b1};
    tbl[18] = '{1'b0, JNK, 1'b0, 1'b0, 32'h0,         1'b1, 32'h208,       NOP, 32'h0,   1'b0};
    tbl[19] = '{1'b1, W8,  1'b1, 1'b0, 32'h0,         1'b0, 32'h20C,       NOP, 32'h0,   1'b0};
    tbl[20] = '{1'b0, JNK, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC, NOP, 32'h0,   1'b0};
    tbl[21] = '{1'b1, W9,  1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         W9,  32'h0,   1'b1};
    tbl[22] = '{1'b1, W10, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         W10, 32'h4,   1'b1};
    tbl[23] = '{1'b1, JNK, 1'b1, 1'b1, 32'h40,        1'b1, 32'h40,        NOP, 32'h0,   1'b0};

    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 32'h0, NOP, 32'h0, 1'b0, 1'b1);
    #3 reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].rdy, tbl[i].rdata, tbl[i].stl, tbl[i].br, tbl[i].tgt);
      step();
      check($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_instr,
            tbl[i].e_pc4, tbl[i].e_valid, tbl[i].e_valid);
    end

    // Asynchronous reset while a request is waiting on memory.
    drive(1'b1, W2, 1'b0, 1'b0, 32'h0);
    step();
    check("pre_rst_fetch", 1'b1, 32'h44, W2, 32'h44, 1'b1, 1'b1);
    drive(1'b0, JNK, 1'b0, 1'b0, 32'h0);
    step();
    check("pre_rst_wait", 1'b0 | 1'b1, 32'h44, NOP, 32'h0, 1'b0, 1'b0);
    #3 reset = 1'b0;
    #1 check("async_rst", 1'b0, 32'h0, NOP, 32'h0, 1'b0, 1'b1);
    drive(1'b1, JNK, 1'b0, 1'b0, 32'h0);
    step();
    check("rst_held", 1'b0, 32'h0, NOP, 32'h0, 1'b0, 1'b1);
    #3 reset = 1'b1;
    drive(1'b1, R, 1'b0, 1'b0, 32'h0);
    step();
    check("restart_req", 1'b1, 32'h0, NOP, 32'h0, 1'b0, 1'b0);
    step();
    check("restart_fetch", 1'b1, 32'h4, R, 32'h4, 1'b1, 1'b1);

    // Randomized traffic against the reference model.
    reset = 1'b0;
    #1;
    model_reset();
    #3 reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic        r_rdy, r_stl, r_br;
      logic [31:0] r_rd, r_tgt;
      r_rdy = ($urandom_range(99, 0) < 60);
      r_stl = ($urandom_range(99, 0) < 25);
      r_br  = ($urandom_range(99, 0) < 8);
      r_rd  = $urandom;
      r_tgt = $urandom;
      drive(r_rdy, r_rd, r_stl, r_br, r_tgt);
      model_step(r_rdy, r_rd, r_stl, r_br, r_tgt);
      step();
      check($sformatf("rand%0d", c), m_req, m_pc, m_instr, m_pc4, m_valid, m_valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
